// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared packet layout, AHB transfer encodings and front-end FSM states
package bridge_pkg;

    localparam int PKT_W    = 41;
    localparam int WR_BIT   = 40;
    localparam int DATA_MSB = 39;
    localparam int DATA_LSB = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_DATA = 3'd1;
    localparam logic [2:0] ST_RD_REQ  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
`ifdef AHB_ERR_RESP_EN
    localparam logic [2:0] ST_ERR1    = 3'd4;
    localparam logic [2:0] ST_ERR2    = 3'd5;
`endif

    function automatic logic htrans_active(input logic [1:0] trans);
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic [PKT_W-1:0] make_pkt(input logic wr, input logic [31:0] data,
                                                  input logic [7:0] addr);
        logic [PKT_W-1:0] pkt;
        pkt                     = '0;
        pkt[WR_BIT]             = wr;
        pkt[DATA_MSB:DATA_LSB]  = data;
        pkt[ADDR_MSB:ADDR_LSB]  = addr;
        return pkt;
    endfunction

endpackage

// File: rtl/packet_fifo.sv
// rtl/packet_fifo.sv - synchronous show-ahead FIFO; dout is the head entry, zero when empty
module packet_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] dout_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ahb_packet_frontend.sv
// rtl/ahb_packet_frontend.sv - AHB-Lite slave turning transfers into APB-side packets
// AHB_ERR_RESP_EN enables the two-cycle ERROR response for non-word or unaligned transfers.
module ahb_packet_frontend
    import bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             PCLK,
    input  logic             RESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic             HRESP,
    output logic [31:0]      HRDATA,
    output logic [PKT_W-1:0] Packet_OUT,
    output logic             P_Valid,
    input  logic             Packet_Read_en,
    input  logic [31:0]      Read_Data_IN,
    input  logic             Read_Data_Valid,
    output logic             Read_Data_Pop
);

    logic [2:0]       state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic [2:0]       phase_next;
    logic             accept, take_addr;
    logic             fifo_push, fifo_full, fifo_empty;
    logic [PKT_W-1:0] pkt_in;
    logic             unused_bits;

`ifdef AHB_ERR_RESP_EN
    assign unused_bits = ^HADDR[31:8];
`else
    assign unused_bits = ^{HSIZE, HADDR[31:8]};
`endif

    // State that follows a completing data phase, given the address phase sampled alongside it.
    always_comb begin
        accept     = HSEL && HREADY && htrans_active(HTRANS);
        phase_next = ST_IDLE;
        if (accept) begin
            phase_next = HWRITE ? ST_WR_DATA : ST_RD_REQ;
`ifdef AHB_ERR_RESP_EN
            if (HSIZE != 3'b010 || HADDR[1:0] != 2'b00) begin
                phase_next = ST_ERR1;
            end
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        take_addr     = 1'b0;
        fifo_push     = 1'b0;
        pkt_in        = make_pkt(1'b1, HWDATA, addr_q);
        HREADYOUT     = 1'b1;
        HRESP         = 1'b0;
        HRDATA        = '0;
        Read_Data_Pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                take_addr = 1'b1;
                state_d   = phase_next;
            end
            ST_WR_DATA: begin
                if (fifo_full) begin
                    HREADYOUT = 1'b0;
                end else begin
                    fifo_push = 1'b1;
                    take_addr = 1'b1;
                    state_d   = phase_next;
                end
            end
            ST_RD_REQ: begin
                HREADYOUT = 1'b0;
                pkt_in    = make_pkt(1'b0, 32'h0, addr_q);
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    state_d   = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                HREADYOUT     = Read_Data_Valid;
                Read_Data_Pop = Read_Data_Valid;
                if (Read_Data_Valid) begin
                    HRDATA    = Read_Data_IN;
                    take_addr = 1'b1;
                    state_d   = phase_next;
                end
            end
`ifdef AHB_ERR_RESP_EN
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        addr_d = (take_addr && accept) ? HADDR[7:0] : addr_q;
    end

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    packet_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (PCLK),
        .rst_i   (RESET),
        .push_i  (fifo_push),
        .din_i   (pkt_in),
        .pop_i   (Packet_Read_en),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .dout_o  (Packet_OUT)
    );

    assign P_Valid = !fifo_empty;

endmodule

// File: tb/tb_ahb_packet_frontend.sv
// tb/tb_ahb_packet_frontend.sv - cycle-vector table plus reset and error-response sequences
module tb_ahb_packet_frontend;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BY = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam int NV = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel, hwrite, hready, hreadyout, hresp;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [40:0] pkt_out;
    logic        p_valid, pkt_rd_en;
    logic [31:0] rd_data;
    logic        rd_valid, rd_pop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    assign hready = hreadyout;

    ahb_packet_frontend #(.FIFO_DEPTH(4)) dut (
        .PCLK            (clk),
        .RESET           (rst),
        .HSEL            (hsel),
        .HADDR           (haddr),
        .HTRANS          (htrans),
        .HWRITE          (hwrite),
        .HSIZE           (hsize),
        .HWDATA          (hwdata),
        .HREADY          (hready),
        .HREADYOUT       (hreadyout),
        .HRESP           (hresp),
        .HRDATA          (hrdata),
        .Packet_OUT      (pkt_out),
        .P_Valid         (p_valid),
        .Packet_Read_en  (pkt_rd_en),
        .Read_Data_IN    (rd_data),
        .Read_Data_Valid (rd_valid),
        .Read_Data_Pop   (rd_pop)
    );

    typedef struct packed {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        pop;
        logic        rdv;
        logic [31:0] rdata;
        logic        e_rdy;
        logic        e_pv;
        logic [40:0] e_pkt;
        logic        e_rpop;
        logic [31:0] e_hrdata;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                input logic [7:0] addr, input logic [31:0] wdata,
                                input logic pop, input logic rdv, input logic [31:0] rdata,
                                input logic e_rdy, input logic e_pv, input logic [40:0] e_pkt,
                                input logic e_rpop, input logic [31:0] e_hrdata);
        vec_t v;
        v = '{sel, tr, wr, addr, wdata, pop, rdv, rdata, e_rdy, e_pv, e_pkt, e_rpop, e_hrdata};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge; callers check at the falling edge.
    task automatic step(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [7:0] addr, input logic [31:0] wdata, input logic pop,
                        input logic rdv, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        hsel      = sel;
        htrans    = tr;
        hwrite    = wr;
        haddr     = {24'h0, addr};
        hwdata    = wdata;
        pkt_rd_en = pop;
        rd_valid  = rdv;
        rd_data   = rdata;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        hsel = 1'b0; htrans = ID; hwrite = 1'b0; haddr = '0; hwdata = '0;
        hsize = 3'b010; pkt_rd_en = 1'b0; rd_valid = 1'b0; rd_data = '0;

        vecs[0]  = mk(1, NS, 1, 8'h14, 32'h0,        0, 0, 32'h0,        1, 0, 41'h0, 0, 32'h0);
        vecs[1]  = mk(0, ID, 0, 8'h00, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 41'h0, 0, 32'h0);
        vecs[2]  = mk(0, ID, 0, 8'h00, 32'h0,        1, 0, 32'h0,        1, 1, 41'h1_DEADBEEF_14, 0, 32'h0);
        vecs[3]  = mk(1, NS, 1, 8'h00, 32'h0,        0, 0, 32'h0,        1, 0, 41'h0, 0, 32'h0);
        vecs[4]  = mk(1, NS, 1, 8'h04, 32'hA0000000, 0, 0, 32'h0,        1, 0, 41'h0, 0, 32'h0);
        vecs[5]  = mk(1, NS, 1, 8'h08, 32'hA0000001, 0, 0, 32'h0,        1, 1, 41'h1_A0000000_00, 0, 32'h0);
        vecs[6]  = mk(1, NS, 1, 8'h0C, 32'hA0000002, 0, 0, 32'h0,        1, 1, 41'h1_A0000000_00, 0, 32'h0);
        vecs[7]  = mk(1, NS, 1, 8'h10, 32'hA0000003, 0, 0, 32'h0,        1, 1, 41'h1_A0000000_00, 0, 32'h0);
        vecs[8]  = mk(0, ID, 0, 8'h00, 32'hA0000004, 0, 0, 32'h0,        0, 1, 41'h1_A0000000_00, 0, 32'h0);
        vecs[9]  = mk(0, ID, 0, 8'h00, 32'hA0000004, 1, 0, 32'h0,        0, 1, 41'h1_A0000000_00, 0, 32'h0);
        vecs[10] = mk(0, ID, 0, 8'h00, 32'hA0000004, 0, 0, 32'h0,        1, 1, 41'h1_A0000001_04, 0, 32'h0);
        vecs[11] = mk(0, ID, 0, 8'h00, 32'h0,        1, 0, 32'h0,        1, 1, 41'h1_A0000001_04, 0, 32'h0);
        vecs[12] = mk(0, ID, 0, 8'h00, 32'h0,        1, 0, 32'h0,        1, 1, 41'h1_A0000002_08, 0, 32'h0);
        vecs[13] = mk(0, ID, 0, 8'h00, 32'h0,        1, 0, 32'h0,        1, 1, 41'h1_A0000003_0C, 0, 32'h0);
        vecs[14] = mk(0, ID, 0, 8'h00, 32'h0,        1, 0, 32'h0,        1, 1, 41'h1_A0000004_10, 0, 32'h0);
        vecs[15] = mk(1, BY, 1, 8'h50, 32'h0,        0, 0, 32'h0,        1, 0, 41'h0, 0, 32'h0);
        vecs[16] = mk(0, NS, 1, 8'h54, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 0, 41'h0, 0, 32'h0);
        vecs[17] = mk(0, ID, 0, 8'h00, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 0, 41'h0, 0, 32'h0);
        vecs[18] = mk(1, NS, 0, 8'h20, 32'h0,        0, 0, 32'h0,        1, 0, 41'h0, 0, 32'h0);
        vecs[19] = mk(0, ID, 0, 8'h00, 32'h0,        0, 0, 32'h0,        0, 0, 41'h0, 0, 32'h0);
        vecs[20] = mk(0, ID, 0, 8'h00, 32'h0,        1, 0, 32'h0,        0, 1, 41'h0_00000000_20, 0, 32'h0);
        vecs[21] = mk(0, ID, 0, 8'h00, 32'h0,        0, 0, 32'h0,        0, 0, 41'h0, 0, 32'h0);
        vecs[22] = mk(0, ID, 0, 8'h00, 32'h0,        0, 1, 32'h12345678, 1, 0, 41'h0, 1, 32'h12345678);
        vecs[23] = mk(0, ID, 0, 8'h00, 32'h0,        0, 1, 32'hCAFEF00D, 1, 0, 41'h0, 0, 32'h0);
        vecs[24] = mk(1, NS, 1, 8'h08, 32'h0,        0, 0, 32'h0,        1, 0, 41'h0, 0, 32'h0);
        vecs[25] = mk(1, NS, 0, 8'h08, 32'h0BADCAFE, 0, 0, 32'h0,        1, 0, 41'h0, 0, 32'h0);
        vecs[26] = mk(0, ID, 0, 8'h00, 32'h0,        1, 0, 32'h0,        0, 1, 41'h1_0BADCAFE_08, 0, 32'h0);
        vecs[27] = mk(0, ID, 0, 8'h00, 32'h0,        1, 0, 32'h0,        0, 1, 41'h0_00000000_08, 0, 32'h0);
        vecs[28] = mk(0, ID, 0, 8'h00, 32'h0,        0, 1, 32'h87654321, 1, 0, 41'h0, 1, 32'h87654321);
        vecs[29] = mk(0, ID, 0, 8'h00, 32'h0,        0, 0, 32'h0,        1, 0, 41'h0, 0, 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hreadyout", 64'(hreadyout), 64'(1'b1));
        chk("reset_hresp", 64'(hresp), 64'(1'b0));
        chk("reset_pvalid", 64'(p_valid), 64'(1'b0));
        chk("reset_rdpop", 64'(rd_pop), 64'(1'b0));
        chk("reset_hrdata", 64'(hrdata), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].sel, vecs[i].tr, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].pop, vecs[i].rdv, vecs[i].rdata);
            chk($sformatf("v%0d_hreadyout", i), 64'(hreadyout), 64'(vecs[i].e_rdy));
            chk($sformatf("v%0d_pvalid", i), 64'(p_valid), 64'(vecs[i].e_pv));
            if (vecs[i].e_pv) begin
                chk($sformatf("v%0d_packet", i), 64'(pkt_out), 64'(vecs[i].e_pkt));
            end
            chk($sformatf("v%0d_rdpop", i), 64'(rd_pop), 64'(vecs[i].e_rpop));
            chk($sformatf("v%0d_hrdata", i), 64'(hrdata), 64'(vecs[i].e_hrdata));
            chk($sformatf("v%0d_hresp", i), 64'(hresp), 64'(1'b0));
        end

        // Reset while a read waits in RD_WAIT with a write and a read packet queued.
        step(1, NS, 1, 8'h30, 32'h0, 0, 0, 32'h0);
        step(1, NS, 0, 8'h34, 32'h11112222, 0, 0, 32'h0);
        step(0, ID, 0, 8'h00, 32'h0, 0, 0, 32'h0);
        step(0, ID, 0, 8'h00, 32'h0, 0, 0, 32'h0);
        chk("prerst_pvalid", 64'(p_valid), 64'(1'b1));
        chk("prerst_hreadyout", 64'(hreadyout), 64'(1'b0));
        @(posedge clk);
        #1;
        rst      = 1'b1;
        rd_valid = 1'b1;
        rd_data  = 32'h55AA55AA;
        #1;
        chk("midrst_pvalid", 64'(p_valid), 64'(1'b0));
        chk("midrst_hreadyout", 64'(hreadyout), 64'(1'b1));
        chk("midrst_rdpop", 64'(rd_pop), 64'(1'b0));
        chk("midrst_hrdata", 64'(hrdata), 64'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rd_valid = 1'b0;
        step(1, NS, 1, 8'h3C, 32'h0, 0, 0, 32'h0);
        step(0, ID, 0, 8'h00, 32'h13579BDF, 0, 0, 32'h0);
        chk("postrst_wr_hreadyout", 64'(hreadyout), 64'(1'b1));
        chk("postrst_wr_pvalid", 64'(p_valid), 64'(1'b0));
        step(0, ID, 0, 8'h00, 32'h0, 1, 0, 32'h0);
        chk("postrst_pvalid", 64'(p_valid), 64'(1'b1));
        chk("postrst_packet", 64'(pkt_out), 64'(41'h1_13579BDF_3C));
        step(0, ID, 0, 8'h00, 32'h0, 0, 0, 32'h0);
        chk("postrst_drained", 64'(p_valid), 64'(1'b0));

`ifdef AHB_ERR_RESP_EN
        hsize = 3'b000;
        step(1, NS, 1, 8'h40, 32'h0, 0, 0, 32'h0);
        chk("err_addr_hreadyout", 64'(hreadyout), 64'(1'b1));
        hsize = 3'b010;
        step(0, ID, 0, 8'h00, 32'h77777777, 0, 0, 32'h0);
        chk("err1_hreadyout", 64'(hreadyout), 64'(1'b0));
        chk("err1_hresp", 64'(hresp), 64'(1'b1));
        chk("err1_pvalid", 64'(p_valid), 64'(1'b0));
        step(0, ID, 0, 8'h00, 32'h77777777, 0, 0, 32'h0);
        chk("err2_hreadyout", 64'(hreadyout), 64'(1'b1));
        chk("err2_hresp", 64'(hresp), 64'(1'b1));
        step(0, ID, 0, 8'h00, 32'h0, 0, 0, 32'h0);
        chk("errdone_hresp", 64'(hresp), 64'(1'b0));
        chk("errdone_hreadyout", 64'(hreadyout), 64'(1'b1));
        chk("errdone_pvalid", 64'(p_valid), 64'(1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
